// File: rtl/ysyx_23060236_sram.sv
// AXI4 slave word SRAM with FIXED/INCR bursts, byte strobes and ID echo.
// One FSM owns every channel handshake, so reads and writes never overlap.
module ysyx_23060236_sram #(
    parameter int ADDR_W   = 12,
    parameter int RD_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    output logic        arready,
    input  logic        arvalid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic [3:0]  rid
);

    typedef enum logic [2:0] {
        IDLE,
        RWAIT,
        RDATA,
        WDATA,
        WRESP
    } state_t;

    state_t state, state_nx;

    logic              prio_rd;
    logic [3:0]        id_q;
    logic [31:0]       addr_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_cnt;
    logic [3:0]        dly_cnt;
    logic              err;
    logic              ar_gnt;
    logic              aw_gnt;
    logic              at_last;
    logic [31:0]       addr_nx;
    logic [ADDR_W-1:0] idx_cur;
    logic [ADDR_W-1:0] idx_nx;
    logic [ADDR_W-1:0] idx_ar;

    logic [31:0] mem [2**ADDR_W];

    // Reset gates the grants so no ready leaks out while reset is held.
    assign ar_gnt  = (state == IDLE) & ~reset & arvalid & (prio_rd | ~awvalid);
    assign aw_gnt  = (state == IDLE) & ~reset & awvalid & (~prio_rd | ~arvalid);
    assign at_last = (beat_cnt == len_q);
    assign addr_nx = (burst_q == 2'b00) ? addr_q : addr_q + (32'd1 << size_q);
    assign idx_cur = addr_q[ADDR_W+1:2];
    assign idx_nx  = addr_nx[ADDR_W+1:2];
    assign idx_ar  = araddr[ADDR_W+1:2];

    assign rid   = id_q;
    assign bid   = id_q;
    assign rresp = 2'b00;
    assign bresp = err ? 2'b10 : 2'b00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        arready  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        rvalid   = 1'b0;
        rlast    = 1'b0;
        bvalid   = 1'b0;
        unique case (state)
            IDLE: begin
                arready = ar_gnt;
                awready = aw_gnt;
                if (ar_gnt)      state_nx = (RD_DELAY == 0) ? RDATA : RWAIT;
                else if (aw_gnt) state_nx = WDATA;
            end
            RWAIT: if (dly_cnt <= 4'd1) state_nx = RDATA;
            RDATA: begin
                rvalid = 1'b1;
                rlast  = at_last;
                if (rready && at_last) state_nx = IDLE;
            end
            WDATA: begin
                wready = 1'b1;
                if (wvalid && (wlast || at_last)) state_nx = WRESP;
            end
            WRESP: begin
                bvalid = 1'b1;
                if (bready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_rd  <= 1'b1;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_cnt <= '0;
            dly_cnt  <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ar_gnt) begin
                        id_q     <= arid;
                        addr_q   <= araddr;
                        len_q    <= arlen;
                        size_q   <= arsize;
                        burst_q  <= arburst;
                        beat_cnt <= '0;
                        dly_cnt  <= 4'(RD_DELAY);
                        prio_rd  <= 1'b0;
                        if (RD_DELAY == 0) rdata <= mem[idx_ar];
                    end else if (aw_gnt) begin
                        id_q     <= awid;
                        addr_q   <= awaddr;
                        len_q    <= awlen;
                        size_q   <= awsize;
                        burst_q  <= awburst;
                        beat_cnt <= '0;
                        prio_rd  <= 1'b1;
                    end
                end
                RWAIT: begin
                    dly_cnt <= dly_cnt - 4'd1;
                    if (dly_cnt <= 4'd1) rdata <= mem[idx_cur];
                end
                RDATA: begin
                    if (rready && !at_last) begin
                        addr_q   <= addr_nx;
                        beat_cnt <= beat_cnt + 8'd1;
                        rdata    <= mem[idx_nx];
                    end
                end
                WDATA: begin
                    if (wvalid) begin
                        addr_q   <= addr_nx;
                        beat_cnt <= beat_cnt + 8'd1;
                        // Early or missing wlast still writes, but flags SLVERR.
                        if ((wlast || at_last) && (wlast != at_last)) err <= 1'b1;
                    end
                end
                WRESP: if (bready) err <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (state == WDATA && wvalid) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx_cur][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_sram.sv
// Self-checking bench for ysyx_23060236_sram: directed vectors,
// multi-cycle corner sequences and randomized traffic against a memory model.
module tb_ysyx_23060236_sram;

    localparam int RD_DELAY = 2;

    logic        clock;
    logic        reset;
    logic        awready, awvalid;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wready, wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arready, arvalid;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready, rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;

    ysyx_23060236_sram #(.ADDR_W(12), .RD_DELAY(RD_DELAY)) dut (
        .clock(clock), .reset(reset),
        .awready(awready), .awvalid(awvalid), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wready(wready), .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bready(bready), .bvalid(bvalid), .bresp(bresp), .bid(bid),
        .arready(arready), .arvalid(arvalid), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rready(rready), .rvalid(rvalid), .rresp(rresp), .rdata(rdata),
        .rlast(rlast), .rid(rid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [31:0] model [4096];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] rexp [16];

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  wid;
        logic [31:0] wdat;
        logic [3:0]  wstb;
        logic [31:0] raddr;
        logic [3:0]  rdid;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] bu,
                                         input logic [2:0] sz);
        return (bu == 2'b00) ? a : a + (32'd1 << sz);
    endfunction

    function automatic void model_fill(input logic [31:0] a, input logic [7:0] len,
                                       input logic [1:0] bu, input logic [2:0] sz);
        logic [31:0] p;
        p = a;
        for (int b = 0; b <= int'(len); b++) begin
            rexp[b] = model[widx(p)];
            p = step(p, bu, sz);
        end
    endfunction

    task automatic idle_inputs();
        awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        rready = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] bu, input logic [2:0] sz, input int nbeats,
                            input int wlast_beat, output logic [1:0] resp, output logic [3:0] bo);
        int n;
        logic [31:0] p;
        @(negedge clock);
        awvalid = 1; awaddr = a; awid = id; awlen = len; awsize = sz; awburst = bu;
        #1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clock); #1; n++; end
        chk("awready", 32'(awready), 32'd1);
        @(negedge clock);
        awvalid = 0;
        p = a;
        for (int b = 0; b < nbeats; b++) begin
            wvalid = 1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_beat);
            #1;
            n = 0;
            while (!wready && n < 50) begin @(negedge clock); #1; n++; end
            chk("wready", 32'(wready), 32'd1);
            for (int i = 0; i < 4; i++)
                if (ws[b][i]) model[widx(p)][8*i +: 8] = wd[b][8*i +: 8];
            p = step(p, bu, sz);
            @(negedge clock);
        end
        wvalid = 0; wlast = 0;
        #1;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clock); #1; n++; end
        chk("b_latency", 32'(n), 32'd0);
        resp = bresp;
        bo = bid;
        bready = 1;
        @(negedge clock);
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] bu, input logic [2:0] sz,
                           input int stall_beat, input int stall_n);
        int n;
        logic [31:0] hold;
        @(negedge clock);
        arvalid = 1; araddr = a; arid = id; arlen = len; arsize = sz; arburst = bu;
        #1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clock); #1; n++; end
        chk("arready", 32'(arready), 32'd1);
        @(negedge clock);
        arvalid = 0;
        rready = 1;
        #1;
        n = 0;
        while (!rvalid && n < 50) begin @(negedge clock); #1; n++; end
        chk("r_latency", 32'(n), 32'(RD_DELAY));
        for (int b = 0; b <= int'(len); b++) begin
            chk("rvalid", 32'(rvalid), 32'd1);
            chk("rdata", rdata, rexp[b]);
            chk("rid", 32'(rid), 32'(id));
            chk("rlast", 32'(rlast), 32'(b == int'(len)));
            if (b == 0) chk("rresp", 32'(rresp), 32'd0);
            if (b == stall_beat) begin
                rready = 0;
                hold = rdata;
                repeat (stall_n) begin
                    @(negedge clock); #1;
                    chk("stall_rdata", rdata, hold);
                    chk("stall_rvalid", 32'(rvalid), 32'd1);
                    chk("stall_rlast", 32'(rlast), 32'(b == int'(len)));
                end
                rready = 1;
            end
            @(negedge clock); #1;
        end
        rready = 0;
        chk("r_done", 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [3:0]  bo;
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  bu;
        logic [2:0]  sz;
        logic [3:0]  id;
        int grant [3];
        int ng, viol;

        vt[0] = '{32'h0000_0100, 4'd3,  32'hDEADBEEF, 4'hF, 32'h0000_0100, 4'd5,  32'hDEADBEEF};
        vt[1] = '{32'h0000_0104, 4'd7,  32'h11223344, 4'hF, 32'h0000_0104, 4'd1,  32'h11223344};
        vt[2] = '{32'h0000_0104, 4'd8,  32'hAABBCCDD, 4'h5, 32'h0000_0104, 4'd2,  32'h11BB33DD};
        vt[3] = '{32'h0000_0104, 4'd0,  32'hFFFFFFFF, 4'h0, 32'h0000_0104, 4'd15, 32'h11BB33DD};
        vt[4] = '{32'h0000_4108, 4'd4,  32'h0BADF00D, 4'hF, 32'h0000_0108, 4'd6,  32'h0BADF00D};
        vt[5] = '{32'h0000_3FFC, 4'd12, 32'h55AA55AA, 4'hF, 32'hFFFF_FFFC, 4'd10, 32'h55AA55AA};

        // Reset held with random inputs: nothing may handshake.
        reset = 1;
        idle_inputs();
        repeat (6) begin
            @(negedge clock);
            awvalid = 1'($urandom); awaddr = $urandom; awlen = 8'($urandom);
            wvalid = 1'($urandom); wdata = $urandom; wstrb = 4'($urandom); wlast = 1'($urandom);
            arvalid = 1'($urandom); araddr = $urandom; arlen = 8'($urandom);
            rready = 1'($urandom); bready = 1'($urandom);
            #1;
            chk("rst_arready", 32'(arready), 32'd0);
            chk("rst_awready", 32'(awready), 32'd0);
            chk("rst_wready", 32'(wready), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_bvalid", 32'(bvalid), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end
        @(negedge clock);
        idle_inputs();
        reset = 0;

        // Arbitration: both requests held from reset, grants must alternate R, W, R.
        arvalid = 1; araddr = 32'h100; arid = 4'd1; arlen = 0; arsize = 3'd2; arburst = 2'b01;
        awvalid = 1; awaddr = 32'h300; awid = 4'd2; awlen = 0; awsize = 3'd2; awburst = 2'b01;
        wvalid = 1; wdata = 32'h0; wstrb = 4'h0; wlast = 1; rready = 1; bready = 1;
        ng = 0;
        viol = 0;
        for (int c = 0; c < 60 && ng < 3; c++) begin
            #1;
            if (arready && awready) viol++;
            if ((arready || awready) && (rvalid || wready || bvalid)) viol++;
            if (arready) begin grant[ng] = 0; ng++; end
            else if (awready) begin grant[ng] = 1; ng++; end
            @(negedge clock);
        end
        idle_inputs();
        rready = 1;
        repeat (8) @(negedge clock);
        rready = 0;
        chk("arb_count", 32'(ng), 32'd3);
        chk("arb_grant0", 32'(grant[0]), 32'd0);
        chk("arb_grant1", 32'(grant[1]), 32'd1);
        chk("arb_grant2", 32'(grant[2]), 32'd0);
        chk("arb_overlap", 32'(viol), 32'd0);

        // Directed single-beat write/readback vectors.
        for (int v = 0; v < 6; v++) begin
            wd[0] = vt[v].wdat;
            ws[0] = vt[v].wstb;
            do_write(vt[v].waddr, vt[v].wid, 8'd0, 2'b01, 3'd2, 1, 0, resp, bo);
            chk("vec_bresp", 32'(resp), 32'd0);
            chk("vec_bid", 32'(bo), 32'(vt[v].wid));
            rexp[0] = vt[v].exp;
            do_read(vt[v].raddr, vt[v].rdid, 8'd0, 2'b01, 3'd2, -1, 0);
        end

        // INCR burst with a two-cycle rready stall.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
        do_write(32'h200, 4'd2, 8'd3, 2'b01, 3'd2, 4, 3, resp, bo);
        chk("incr_bresp", 32'(resp), 32'd0);
        for (int b = 0; b < 4; b++) rexp[b] = 32'(b + 1);
        do_read(32'h200, 4'd7, 8'd3, 2'b01, 3'd2, 1, 2);

        // FIXED burst repeats the same word.
        for (int b = 0; b < 4; b++) rexp[b] = 32'h11BB33DD;
        do_read(32'h104, 4'd3, 8'd3, 2'b00, 3'd2, -1, 0);

        // Early wlast: len=3 but wlast on the second beat.
        wd[0] = 32'hA0A0A0A0; wd[1] = 32'hA1A1A1A1; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(32'h280, 4'd11, 8'd3, 2'b01, 3'd2, 2, 1, resp, bo);
        chk("early_wlast_bresp", 32'(resp), 32'd2);
        chk("early_wlast_bid", 32'(bo), 32'd11);
        rexp[0] = 32'hA0A0A0A0; rexp[1] = 32'hA1A1A1A1;
        do_read(32'h280, 4'd4, 8'd1, 2'b01, 3'd2, -1, 0);
        // Missing wlast on the final beat also errors.
        wd[0] = 32'hB0B0B0B0; wd[1] = 32'hB1B1B1B1;
        do_write(32'h290, 4'd12, 8'd1, 2'b01, 3'd2, 2, -1, resp, bo);
        chk("no_wlast_bresp", 32'(resp), 32'd2);
        // Error flag must clear for the next good burst.
        wd[0] = 32'hC0C0C0C0;
        do_write(32'h298, 4'd13, 8'd0, 2'b01, 3'd2, 1, 0, resp, bo);
        chk("err_clear_bresp", 32'(resp), 32'd0);
        rexp[0] = 32'hB0B0B0B0; rexp[1] = 32'hB1B1B1B1;
        do_read(32'h290, 4'd5, 8'd1, 2'b01, 3'd2, -1, 0);

        // Async reset in the middle of a read burst.
        @(negedge clock);
        arvalid = 1; araddr = 32'h200; arid = 4'd9; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01;
        #1;
        ng = 0;
        while (!arready && ng < 50) begin @(negedge clock); #1; ng++; end
        chk("ar_rst_arready", 32'(arready), 32'd1);
        @(negedge clock);
        arvalid = 0;
        rready = 1;
        #1;
        ng = 0;
        while (!rvalid && ng < 50) begin @(negedge clock); #1; ng++; end
        chk("ar_rst_beat0", rdata, 32'd1);
        @(negedge clock); #1;
        chk("ar_rst_beat1", rdata, 32'd2);
        #2;
        reset = 1;
        #1;
        chk("async_rst_rvalid", 32'(rvalid), 32'd0);
        chk("async_rst_rdata", rdata, 32'd0);
        chk("async_rst_rlast", 32'(rlast), 32'd0);
        @(negedge clock);
        idle_inputs();
        reset = 0;
        for (int b = 0; b < 4; b++) rexp[b] = 32'(b + 1);
        do_read(32'h200, 4'd8, 8'd3, 2'b01, 3'd2, -1, 0);

        // Prefill a 1 KiB window, then random traffic against the model.
        for (int k = 0; k < 16; k++) begin
            for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
            do_write(32'(k * 64), 4'(k), 8'd15, 2'b01, 3'd2, 16, 15, resp, bo);
            chk("prefill_bresp", 32'(resp), 32'd0);
        end
        for (int it = 0; it < 40; it++) begin
            a   = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 240)) << 2);
            len = 8'($urandom_range(0, 3));
            bu  = 2'($urandom_range(0, 3));
            sz  = 3'($urandom_range(0, 2));
            id  = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                do_write(a, id, len, bu, sz, int'(len) + 1, int'(len), resp, bo);
                chk("rand_bresp", 32'(resp), 32'd0);
                chk("rand_bid", 32'(bo), 32'(id));
            end else begin
                model_fill(a, len, bu, sz);
                do_read(a, id, len, bu, sz, $urandom_range(0, 4), $urandom_range(0, 2));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
